// File: rtl/cache_types_pkg.sv
// Shared types for the cache-line/memory-burst adaptor: FSM state encoding and
// the beat-count helper used to size the beat counter.
package cache_types_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdDone,
    StWr,
    StWrDone
  } adaptor_state_t;

  function automatic int unsigned nbeats(input int unsigned line_w, input int unsigned burst_w);
    return line_w / burst_w;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor.
// The slave modport is the adaptor's view; master is the cache/memory environment.
interface cacheline_adaptor_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64,
  parameter int unsigned s_addr  = 32
);
  // cache side
  logic                read_i;
  logic                write_i;
  logic [s_addr-1:0]   address_i;
  logic [s_line-1:0]   line_i;
  logic [s_line-1:0]   line_o;
  logic                resp_o;
  // memory side
  logic                read_o;
  logic                write_o;
  logic [s_addr-1:0]   address_o;
  logic [s_burst-1:0]  burst_o;
  logic [s_burst-1:0]  burst_i;
  logic                resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, read_o, write_o, address_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, read_o, write_o, address_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Bridges full-line cache requests to fixed-width memory bursts: gathers read
// beats into a line buffer and splits a written line into beats.
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_addr   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  cacheline_adaptor_if.slave  bus
);

  localparam int unsigned NBeats = nbeats(s_line, s_burst);
  localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NBeats - 1);

  adaptor_state_t    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] buf_q, buf_d;
  logic [s_addr-1:0] addr_aligned;

  // Offset bits of the request address are discarded by alignment.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.address_i[s_offset-1:0];

  assign addr_aligned = {bus.address_i[s_addr-1:s_offset], {s_offset{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        // Read has priority over write when both are requested.
        if (bus.read_i) begin
          addr_d  = addr_aligned;
          cnt_d   = '0;
          state_d = StRd;
        end else if (bus.write_i) begin
          addr_d  = addr_aligned;
          buf_d   = bus.line_i;
          cnt_d   = '0;
          state_d = StWr;
        end
      end
      StRd: begin
        if (bus.resp_i) begin
          buf_d[int'(cnt_q) * s_burst +: s_burst] = bus.burst_i;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StRdDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWr: begin
        if (bus.resp_i) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StWrDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRdDone: state_d = StIdle;
      StWrDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.read_o    = (state_q == StRd);
  assign bus.write_o   = (state_q == StWr);
  assign bus.resp_o    = (state_q == StRdDone) || (state_q == StWrDone);
  assign bus.address_o = addr_q;
  assign bus.line_o    = buf_q;
  assign bus.burst_o   = buf_q[int'(cnt_q) * s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus random
// reads/writes checked against a transaction-level model of line/beat mapping.
module tb_cacheline_adaptor;
  import cache_types_pkg::*;

  localparam int unsigned SOff   = 5;
  localparam int unsigned SLine  = 256;
  localparam int unsigned SBurst = 64;
  localparam int unsigned SAddr  = 32;
  localparam int          NB     = SLine / SBurst;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cacheline_adaptor_if #(.s_line(SLine), .s_burst(SBurst), .s_addr(SAddr)) bus ();

  cacheline_adaptor #(
    .s_offset (SOff),
    .s_line   (SLine),
    .s_burst  (SBurst),
    .s_addr   (SAddr)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [SLine-1:0] rand_line();
    logic [SLine-1:0] v;
    for (int i = 0; i < SLine / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SAddr-1:0] align(input logic [SAddr-1:0] a);
    return (a / (1 << SOff)) * (1 << SOff);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read; memory strobes one beat every (gap+1) cycles. Expected line is
  // simply the beats concatenated with beat 0 in the low bits.
  task automatic run_read(input string name, input logic [SAddr-1:0] addr,
                          input logic [SBurst-1:0] beats[NB], input int gap,
                          input logic also_write);
    logic [SAddr-1:0] ea;
    logic [SLine-1:0] exp_line;
    int k;
    ea = align(addr);
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    bus.read_i    = 1'b1;
    bus.write_i   = also_write;
    bus.address_i = addr;
    bus.line_i    = rand_line();
    tick();
    k = 0;
    for (int cyc = 0; cyc < NB * (gap + 1); cyc++) begin
      n_tests++;
      if ({bus.read_o, bus.write_o, bus.resp_o, bus.address_o} !== {3'b100, ea}) begin
        n_fail++;
        $display("FAIL %s busy cyc%0d: rd/wr/resp/addr got %b%b%b %h, want 100 %h",
                 name, cyc, bus.read_o, bus.write_o, bus.resp_o, bus.address_o, ea);
      end
      if ((cyc % (gap + 1)) == gap) begin
        bus.resp_i  = 1'b1;
        bus.burst_i = beats[k];
        k++;
      end else begin
        bus.resp_i  = 1'b0;
        bus.burst_i = $urandom;
      end
      tick();
    end
    bus.resp_i = 1'b0;
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done: rd/wr/resp got %b%b%b, want 001",
               name, bus.read_o, bus.write_o, bus.resp_o);
    end
    n_tests++;
    if (bus.line_o !== exp_line) begin
      n_fail++;
      $display("FAIL %s line: got %h want %h", name, bus.line_o, exp_line);
    end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    tick();
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o, bus.line_o} !== {3'b000, exp_line}) begin
      n_fail++;
      $display("FAIL %s after: rd/wr/resp got %b%b%b line %h, want 000 %h",
               name, bus.read_o, bus.write_o, bus.resp_o, bus.line_o, exp_line);
    end
  endtask

  // Full write; optionally scrambles cache-side inputs mid-transaction.
  task automatic run_write(input string name, input logic [SAddr-1:0] addr,
                           input logic [SLine-1:0] line, input int gap, input logic perturb);
    logic [SAddr-1:0] ea;
    logic [SBurst-1:0] exp_beat;
    int k;
    ea = align(addr);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b1;
    bus.address_i = addr;
    bus.line_i    = line;
    tick();
    k = 0;
    for (int cyc = 0; cyc < NB * (gap + 1); cyc++) begin
      if (perturb) begin
        bus.address_i = $urandom;
        bus.line_i    = rand_line();
      end
      n_tests++;
      if ({bus.read_o, bus.write_o, bus.resp_o, bus.address_o} !== {3'b010, ea}) begin
        n_fail++;
        $display("FAIL %s busy cyc%0d: rd/wr/resp/addr got %b%b%b %h, want 010 %h",
                 name, cyc, bus.read_o, bus.write_o, bus.resp_o, bus.address_o, ea);
      end
      if ((cyc % (gap + 1)) == gap) begin
        exp_beat = SBurst'(line >> (SBurst * k));
        n_tests++;
        if (bus.burst_o !== exp_beat) begin
          n_fail++;
          $display("FAIL %s beat%0d: got %h want %h", name, k, bus.burst_o, exp_beat);
        end
        bus.resp_i = 1'b1;
        k++;
      end else begin
        bus.resp_i = 1'b0;
      end
      tick();
    end
    bus.resp_i = 1'b0;
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done: rd/wr/resp got %b%b%b, want 001",
               name, bus.read_o, bus.write_o, bus.resp_o);
    end
    bus.write_i = 1'b0;
    tick();
    n_tests++;
    if ({bus.resp_o, bus.write_o, bus.line_o} !== {2'b00, line}) begin
      n_fail++;
      $display("FAIL %s after: resp/wr got %b%b buffer %h, want 00 %h",
               name, bus.resp_o, bus.write_o, bus.line_o, line);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset strobes: got %b%b%b want 000", bus.read_o, bus.write_o, bus.resp_o);
    end
    n_tests++;
    if ({bus.line_o, bus.burst_o, bus.address_o} !== '0) begin
      n_fail++;
      $display("FAIL reset data: line %h burst %h addr %h, want all 0",
               bus.line_o, bus.burst_o, bus.address_o);
    end
    n_tests++;
    if (dut.state_q !== StIdle) begin
      n_fail++;
      $display("FAIL reset state: got %0d want %0d", dut.state_q, StIdle);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_back_to_back();
    logic [SBurst-1:0] b[NB];
    b[0] = {16{4'h1}};
    b[1] = {16{4'h2}};
    b[2] = {16{4'h3}};
    b[3] = {16{4'h4}};
    run_read("read_b2b", 32'h0000_1234, b, 0, 1'b0);
  endtask

  task automatic test_write_gaps();
    run_write("write_gaps", 32'h0000_8008,
              {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2, 1'b0);
  endtask

  task automatic test_simultaneous();
    logic [SBurst-1:0] b[NB];
    for (int i = 0; i < NB; i++) b[i] = {$urandom, $urandom};
    run_read("simul", 32'hDEAD_BEEF, b, 1, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    logic [SBurst-1:0] b[NB];
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_4040;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      tick();
    end
    bus.resp_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.read_o, bus.resp_o, bus.line_o, bus.address_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset async: rd %b resp %b line %h addr %h, want all 0",
               bus.read_o, bus.resp_o, bus.line_o, bus.address_o);
    end
    bus.read_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset resume: rd/wr/resp got %b%b%b want 000",
               bus.read_o, bus.write_o, bus.resp_o);
    end
    for (int i = 0; i < NB; i++) b[i] = {$urandom, $urandom};
    run_read("midreset_reread", 32'h0000_4040, b, 0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    logic [SLine-1:0] line;
    line = rand_line();
    run_write("ignored_wr", 32'h1357_9BDF, line, 1, 1'b1);
    bus.address_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      bus.resp_i = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    n_tests++;
    if ({bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.line_o} !==
        {3'b000, align(32'h1357_9BDF), line}) begin
      n_fail++;
      $display("FAIL idle_resp: rd/wr/resp %b%b%b addr %h line %h, want 000 %h %h",
               bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.line_o,
               align(32'h1357_9BDF), line);
    end
  endtask

  task automatic test_random();
    logic [SBurst-1:0] b[NB];
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(1, 0) == 0) begin
        for (int i = 0; i < NB; i++) b[i] = {$urandom, $urandom};
        run_read("rand_read", $urandom, b, int'($urandom_range(2, 0)), 1'b0);
      end else begin
        run_write("rand_write", $urandom, rand_line(), int'($urandom_range(2, 0)), 1'b0);
      end
    end
  endtask

  initial begin
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    #1;
    test_reset();
    test_read_back_to_back();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_ignored_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
